// File: rtl/search_request_ctrl_pkg.sv
// search_ctrl_pkg: shared state type and constants for the search request controller
package search_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  localparam logic MODE_COUNT = 1'b0;
  localparam logic MODE_SEARCH = 1'b1;
  localparam int RESULT_W = 5;
endpackage

// File: rtl/search_request_ctrl_if.sv
// search_request_ctrl_if: operand/start/done bundle between the controller and the lab 4 engines
interface search_request_ctrl_if;
  import search_ctrl_pkg::*;
  logic [7:0] a_out;
  logic start_count;
  logic start_search;
  logic count_done;
  logic [3:0] count_result;
  logic search_done;
  logic search_found;
  logic [RESULT_W-1:0] search_loc;
  modport master(
    output a_out, start_count, start_search,
    input count_done, count_result, search_done, search_found, search_loc
  );
  modport slave(
    input a_out, start_count, start_search,
    output count_done, count_result, search_done, search_found, search_loc
  );
endinterface

// File: rtl/search_request_ctrl_key_debounce.sv
// key_debounce: 2-flop sync, counted debounce and one-cycle press pulse for an active-low key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync_n;
  logic [CW-1:0] cnt;
  logic db_n;
  always_ff @(posedge clock)
    if (!reset) begin
      sync_n <= 2'b11;
      cnt <= '0;
      db_n <= 1'b1;
      press <= 1'b0;
    end else begin
      sync_n <= {sync_n[0], key_n};
      press <= 1'b0;
      if (sync_n[1] == db_n) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        db_n <= sync_n[1];
        press <= ~sync_n[1];
      end else cnt <= cnt + 1'b1;
    end
  assign pressed = ~db_n;
endmodule

// File: rtl/search_request_ctrl.sv
// search_request_ctrl: debounced start, operand latch, engine start/timeout and result capture
module search_request_ctrl
  import search_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  input  logic [7:0] sw_a,
  input  logic sw_mode,
  search_request_ctrl_if.master eng,
  output logic busy,
  output logic result_valid,
  output logic result_mode,
  output logic [RESULT_W-1:0] result_value,
  output logic result_found,
  output logic timeout
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t state, state_nx;
  logic [7:0] sw_a_s1, sw_a_s2, a_q;
  logic mode_s1, mode_s2, mode_q;
  logic [TW-1:0] tcnt;
  logic key_pressed, press, sel_done, expire;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clock(clock),
    .reset(reset),
    .key_n(key_n),
    .pressed(key_pressed),
    .press(press)
  );
  always_comb begin
    sel_done = mode_q == MODE_SEARCH ? eng.search_done : eng.count_done;
    expire = tcnt == TW'(TIMEOUT_CYCLES - 1);
    state_nx = state == IDLE ? (press ? RUN : IDLE)
             : state == RUN  ? (sel_done || expire ? HOLD : RUN)
             : state == HOLD ? (!sel_done && !key_pressed ? IDLE : HOLD)
             : IDLE;
  end
  always_ff @(posedge clock)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock)
    if (!reset) begin
      sw_a_s1 <= '0;
      sw_a_s2 <= '0;
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      a_q <= '0;
      mode_q <= MODE_COUNT;
      tcnt <= '0;
      result_valid <= 1'b0;
      result_mode <= 1'b0;
      result_value <= '0;
      result_found <= 1'b0;
      timeout <= 1'b0;
    end else begin
      {sw_a_s2, sw_a_s1} <= {sw_a_s1, sw_a};
      {mode_s2, mode_s1} <= {mode_s1, sw_mode};
      tcnt <= state == RUN ? tcnt + 1'b1 : '0;
      if (state == IDLE && press) begin
        a_q <= sw_a_s2;
        mode_q <= mode_s2;
        result_valid <= 1'b0;
        timeout <= 1'b0;
      end
      // done takes priority over the terminal timeout count
      if (state == RUN && sel_done) begin
        result_valid <= 1'b1;
        result_mode <= mode_q;
        result_value <= mode_q == MODE_SEARCH ? eng.search_loc : {1'b0, eng.count_result};
        result_found <= mode_q == MODE_COUNT || eng.search_found;
      end else if (state == RUN && expire) timeout <= 1'b1;
    end
  assign busy = state == RUN;
  assign eng.start_count = busy && mode_q == MODE_COUNT;
  assign eng.start_search = busy && mode_q == MODE_SEARCH;
  assign eng.a_out = a_q;
endmodule
